// File: rtl/three_shuffler_ctrl.sv
// Sequencing controller for a three-word shuffler pipeline.
// Drives the mux selects, the advance enable and the output-valid tracking for one frame at a time.
module three_shuffler_ctrl #(
    parameter int unsigned FRAME_BEATS = 9,
    parameter int unsigned LAT         = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic in_valid,
    output logic sel,
    output logic sel1,
    output logic sel2,
    output logic sel3,
    output logic sel4,
    output logic sel5,
    output logic sel6,
    output logic sel7,
    output logic en,
    output logic out_valid,
    output logic busy,
    output logic frame_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           state_q;
    logic [1:0]       p_q;
    logic [2:0]       c_q;
    logic [15:0]      beat_q;
    logic [3:0]       flush_q;
    logic [1:0]       s2_q;
    logic [7:0]       s3_q;
    logic [LAT-1:0]   v_q;
    logic             done_q;

    logic acc;
    logic adv;
    logic act;
    logic sel_c;
    logic sel3_c;

    assign acc    = (state_q == RUN) && in_valid;
    assign adv    = acc || (state_q == FLUSH);
    assign act    = (state_q != IDLE);
    assign sel_c  = (p_q != 2'd0);
    assign sel3_c = (c_q >= 3'd3);

    // Selects are gated by activity so IDLE and reset present all zeros.
    assign sel        = act && sel_c;
    assign sel1       = act && c_q[0];
    assign sel2       = act && s2_q[1];
    assign sel3       = act && sel3_c;
    assign sel4       = act && s3_q[3];
    assign sel5       = act && (p_q != 2'd1);
    assign sel6       = act && (p_q == 2'd0);
    assign sel7       = act && s3_q[7];
    assign en         = adv;
    assign out_valid  = v_q[LAT-1] && adv;
    assign busy       = act;
    assign frame_done = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= '0;
            c_q     <= '0;
            beat_q  <= '0;
            flush_q <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            v_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (adv) begin
                p_q   <= (p_q == 2'd2) ? 2'd0 : p_q + 2'd1;
                c_q   <= (c_q == 3'd5) ? 3'd0 : c_q + 3'd1;
                s2_q  <= {s2_q[0], sel_c};
                s3_q  <= {s3_q[6:0], sel3_c};
                v_q[0] <= acc;
                for (int i = 1; i < int'(LAT); i++) begin
                    v_q[i] <= v_q[i-1];
                end
            end
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        p_q     <= '0;
                        c_q     <= '0;
                        beat_q  <= '0;
                        flush_q <= '0;
                        s2_q    <= '0;
                        s3_q    <= '0;
                        v_q     <= '0;
                    end
                end
                RUN: begin
                    if (acc) begin
                        beat_q <= beat_q + 16'd1;
                        if (beat_q == 16'(FRAME_BEATS - 1)) begin
                            state_q <= FLUSH;
                            flush_q <= '0;
                        end
                    end
                end
                FLUSH: begin
                    flush_q <= flush_q + 4'd1;
                    if (flush_q == 4'(LAT - 1)) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
